// File: rtl/qarith_pkg.sv
// Shared types for the sign-magnitude Q-format arithmetic unit:
// opcode encoding and control FSM states.
package qarith_pkg;

    localparam int QARITH_N_DEFAULT = 32;
    localparam int QARITH_Q_DEFAULT = 23;

    typedef enum logic [1:0] {
        QOP_ADD = 2'b00,
        QOP_MUL = 2'b01,
        QOP_DIV = 2'b10,
        QOP_SUB = 2'b11
    } qop_e;

    typedef enum logic [1:0] {
        IDLE,
        DIV_RUN,
        RESP
    } qstate_e;

endpackage

// File: rtl/qarith_div_seq.sv
// Sequential restoring divider on unsigned magnitudes.
// Computes (dividend << Q) / divisor, one quotient bit per cycle, N-1+Q cycles.
// done_o is high during the cycle whose closing edge performs the final
// iteration, so the quotient on quot_o is complete from the following cycle.
// Requires Q >= 1 so that the overflow slice above the magnitude is non-empty.
module qarith_div_seq #(
    parameter int N = 32,
    parameter int Q = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [N-2:0] dividend_i,
    input  logic [N-2:0] divisor_i,
    output logic         done_o,
    output logic [N-2:0] quot_o,
    output logic         ovf_o
);

    localparam int W  = N - 1 + Q;
    localparam int CW = $clog2(W + 1);

    // The dividend register shifts out its MSB into the remainder each step
    // and shifts in the new quotient bit at the bottom.
    logic [W-1:0]  dq_q, dq_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-2:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N:0]    remShift;
    logic [N:0]    trial;
    logic          fits;

    // One restoring step: trial-subtract the divisor, keep the result if no borrow
    always_comb begin
        remShift = {rem_q, dq_q[W-1]};
        trial    = remShift - {2'b00, div_q};
        fits     = ~trial[N];
        dq_d     = dq_q;
        rem_d    = rem_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            dq_d  = {dividend_i, {Q{1'b0}}};
            rem_d = '0;
            div_d = divisor_i;
            cnt_d = CW'(W);
        end else if (cnt_q != '0) begin
            rem_d = fits ? trial[N-1:0] : remShift[N-1:0];
            dq_d  = {dq_q[W-2:0], fits};
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Iteration state register; reset abandons any divide in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            dq_q  <= '0;
            rem_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            dq_q  <= dq_d;
            rem_q <= rem_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CW'(1));
    assign quot_o = dq_q[N-2:0];
    assign ovf_o  = |dq_q[W-1:N-1];

endmodule

// File: rtl/qarith_unit.sv
// Sign-magnitude Q-format arithmetic unit: add, sub, mul (single cycle) and
// div (sequential, N+Q cycles), with overflow and divide-by-zero reporting.
// Build option: define QARITH_SAT_EN to saturate the magnitude on overflow;
// otherwise the low N-1 magnitude bits wrap. The ovf flag is identical in both.
module qarith_unit
    import qarith_pkg::*;
#(
    parameter int N = QARITH_N_DEFAULT,
    parameter int Q = QARITH_Q_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   opcode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic         done,
    output logic         busy,
    output logic         ovf
);

    qstate_e state_q, state_d;
    logic [N-1:0] c_q, c_d;
    logic         ovf_q, ovf_d;
    logic         done_q, done_d;
    logic         divSign_q, divSign_d;

    qop_e         op;
    logic [N-2:0] aMag, bMag;
    logic         aSign, bSign, bSignEff;
    logic [N-1:0] sum;
    logic [2*N-3:0] prod, prodShift;
    logic         arithSign, arithOvf;
    logic [N-2:0] arithMag;

    logic         divStart, divLast, divOvf;
    logic [N-2:0] divQuot;

    // Apply the overflow policy and suppress negative zero
    function automatic logic [N-1:0] packResult(input logic sign, input logic [N-2:0] mag,
                                                input logic ovfIn);
        logic [N-2:0] m;
        m = mag;
`ifdef QARITH_SAT_EN
        if (ovfIn) m = '1;
`else
        if (ovfIn) m = mag;
`endif
        return {sign & (|m), m};
    endfunction

    assign op       = qop_e'(opcode);
    assign aMag     = a[N-2:0];
    assign bMag     = b[N-2:0];
    assign aSign    = a[N-1] & (|aMag);
    assign bSign    = b[N-1] & (|bMag);
    assign bSignEff = (op == QOP_SUB) ? (~b[N-1] & (|bMag)) : bSign;

    qarith_div_seq #(.N(N), .Q(Q)) uDiv (
        .clk        (clk),
        .rst        (rst),
        .start_i    (divStart),
        .dividend_i (aMag),
        .divisor_i  (bMag),
        .done_o     (divLast),
        .quot_o     (divQuot),
        .ovf_o      (divOvf)
    );

    // Single-cycle add/sub/mul datapath on magnitudes with separate sign
    always_comb begin
        sum       = {1'b0, aMag} + {1'b0, bMag};
        prod      = {{(N-1){1'b0}}, aMag} * {{(N-1){1'b0}}, bMag};
        prodShift = prod >> Q;
        arithSign = aSign;
        arithMag  = '0;
        arithOvf  = 1'b0;
        if (op == QOP_MUL) begin
            arithSign = aSign ^ bSign;
            arithMag  = prodShift[N-2:0];
            arithOvf  = |prodShift[2*N-3:N-1];
        end else if (aSign == bSignEff) begin
            arithSign = aSign;
            arithMag  = sum[N-2:0];
            arithOvf  = sum[N-1];
        end else if (aMag >= bMag) begin
            arithSign = aSign;
            arithMag  = aMag - bMag;
        end else begin
            arithSign = bSignEff;
            arithMag  = bMag - aMag;
        end
    end

    // Control FSM: next state, result capture and divider launch
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        divSign_d = divSign_q;
        divStart  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op != QOP_DIV) begin
                        c_d    = packResult(arithSign, arithMag, arithOvf);
                        ovf_d  = arithOvf;
                        done_d = 1'b1;
                    end else if (bMag == '0) begin
                        c_d    = {aSign ^ bSign, {(N-1){1'b1}}};
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        divStart  = 1'b1;
                        divSign_d = aSign ^ bSign;
                        state_d   = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                if (divLast) state_d = RESP;
            end
            RESP: begin
                c_d     = packResult(divSign_q, divQuot, divOvf);
                ovf_d   = divOvf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            c_q       <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            divSign_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            divSign_q <= divSign_d;
        end
    end

    assign c    = c_q;
    assign ovf  = ovf_q;
    assign done = done_q;
    assign busy = (state_q == DIV_RUN);

endmodule

// File: tb/tb_qarith_unit.sv
// Directed self-checking bench for qarith_unit at N=32, Q=23.
// Expected values are hand-computed Q8.23 sign-magnitude results.
module tb_qarith_unit;
    import qarith_pkg::*;

`ifdef QARITH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        done;
    logic        busy;
    logic        ovf;

    int numAsserts;
    int numFailures;

    qarith_unit #(.N(32), .Q(23)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .c      (c),
        .done   (done),
        .busy   (busy),
        .ovf    (ovf)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numAsserts++;
        assert (observed === expected)
        else begin
            numFailures++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one request for a single clock edge, return #1 after that edge
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] av,
                                 input logic [31:0] bv);
        start  = 1'b1;
        opcode = op;
        a      = av;
        b      = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Launch a divide and check busy span, latency, pulse width and result
    task automatic runDivide(input string tag, input logic [31:0] av, input logic [31:0] bv,
                             input logic [31:0] expC, input logic expOvf);
        int cycles;
        int busyCount;
        bit sawDone;
        applyStimulus(QOP_DIV, av, bv);
        checkOutput({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        busyCount = int'(busy);
        cycles    = 0;
        sawDone   = 1'b0;
        while (!sawDone && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) sawDone = 1'b1;
            else busyCount += int'(busy);
        end
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd55);
        checkOutput({tag, "_busy_cycles"}, 32'(busyCount), 32'd54);
        checkOutput({tag, "_c"}, c, expC);
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_c_held"}, c, expC);
    endtask

    initial begin
        bit sawDone;
        numAsserts  = 0;
        numFailures = 0;
        rst    = 1'b1;
        start  = 1'b0;
        opcode = 2'b00;
        a      = '0;
        b      = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_c", c, 32'h0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] add/sub/mul back-to-back");
        applyStimulus(QOP_ADD, 32'h00C00000, 32'h01200000);
        checkOutput("add_done", 32'(done), 32'd1);
        checkOutput("add_c", c, 32'h01E00000);
        checkOutput("add_ovf", 32'(ovf), 32'd0);
        applyStimulus(QOP_MUL, 32'h00C00000, 32'h80400000);
        checkOutput("mul_done", 32'(done), 32'd1);
        checkOutput("mul_c", c, 32'h80600000);
        checkOutput("mul_ovf", 32'(ovf), 32'd0);
        applyStimulus(QOP_ADD, 32'h00400000, 32'h80C00000);
        checkOutput("add_mixed_c", c, 32'h80800000);
        applyStimulus(QOP_SUB, 32'h00C00000, 32'h00C00000);
        checkOutput("sub_zero_c", c, 32'h00000000);
        checkOutput("sub_zero_ovf", 32'(ovf), 32'd0);
        applyStimulus(QOP_SUB, 32'h00400000, 32'h80400000);
        checkOutput("sub_neg_b_c", c, 32'h00800000);
        applyStimulus(QOP_MUL, 32'h80000001, 32'h00000001);
        checkOutput("mul_trunc_nozero_c", c, 32'h00000000);
        @(posedge clk);
        #1;
        checkOutput("idle_done_low", 32'(done), 32'd0);

        $display("[TB] divides");
        runDivide("div_pos", 32'h01800000, 32'h00C00000, 32'h01000000, 1'b0);
        runDivide("div_neg", 32'h81800000, 32'h00C00000, 32'h81000000, 1'b0);

        applyStimulus(QOP_DIV, 32'h00800000, 32'h00000000);
        checkOutput("divzero_done", 32'(done), 32'd1);
        checkOutput("divzero_c", c, 32'h7FFFFFFF);
        checkOutput("divzero_ovf", 32'(ovf), 32'd1);
        checkOutput("divzero_busy", 32'(busy), 32'd0);
        applyStimulus(QOP_DIV, 32'h80800000, 32'h80000000);
        checkOutput("divzero_neg_c", c, 32'hFFFFFFFF);
        checkOutput("divzero_neg_ovf", 32'(ovf), 32'd1);

        runDivide("div_ovf", 32'h7F000000, 32'h00000001, SAT ? 32'h7FFFFFFF : 32'h00000000, 1'b1);

        $display("[TB] overflow");
        applyStimulus(QOP_ADD, 32'h7F000000, 32'h7F000000);
        checkOutput("add_ovf_c", c, SAT ? 32'h7FFFFFFF : 32'h7E000000);
        checkOutput("add_ovf_flag", 32'(ovf), 32'd1);
        applyStimulus(QOP_MUL, 32'h7F000000, 32'h01000000);
        checkOutput("mul_ovf_c", c, SAT ? 32'h7FFFFFFF : 32'h7E000000);
        checkOutput("mul_ovf_flag", 32'(ovf), 32'd1);

        $display("[TB] reset during divide");
        applyStimulus(QOP_DIV, 32'h01800000, 32'h00C00000);
        applyStimulus(QOP_ADD, 32'h00400000, 32'h00400000);
        checkOutput("ignored_start_done", 32'(done), 32'd0);
        checkOutput("ignored_start_busy", 32'(busy), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_c", c, 32'h0);
        checkOutput("abort_ovf", 32'(ovf), 32'd0);
        sawDone = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", 32'(sawDone), 32'd0);
        applyStimulus(QOP_ADD, 32'h00C00000, 32'h01200000);
        checkOutput("after_abort_done", 32'(done), 32'd1);
        checkOutput("after_abort_c", c, 32'h01E00000);

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFailures);
        $finish;
    end

endmodule
